// File: rtl/led_pixel_source_pkg.sv
// Shared widths, pixel types and the per-channel brightness scaler for the LED pixel source.
package led_pixel_source_pkg;

   localparam int RGB_W  = 24;
   localparam int CHAN_W = 8;
   localparam int IDX_W  = 16;
   localparam int N_CHAN = RGB_W / CHAN_W;

   typedef logic [RGB_W-1:0] rgb_t;
   typedef logic [IDX_W-1:0] idx_t;

   // (c * (b + 1)) >> 8: b = 255 is identity, b = 0 blanks the channel.
   function automatic logic [CHAN_W-1:0] scale_chan(input logic [CHAN_W-1:0] c,
                                                    input logic [CHAN_W-1:0] b);
      logic [16:0] prod;
      prod = 17'(c) * (17'(b) + 17'd1);
      return CHAN_W'(prod >> CHAN_W);
   endfunction

endpackage

// File: rtl/led_pixel_source_if.sv
// Tape-side request/response and host-side write/commit signals of the pixel source.
interface led_pixel_source_if;
   import led_pixel_source_pkg::*;

   logic       req;
   logic       sync;
   idx_t       num;
   rgb_t       RGB;
   logic       wr_en;
   idx_t       wr_addr;
   rgb_t       wr_data;
   logic       commit;
   logic       commit_pending;
   logic       commit_done;
   logic [7:0] bright;
   logic       rotate_en;

   modport master (
      output req, sync, num, wr_en, wr_addr, wr_data, commit, bright, rotate_en,
      input  RGB, commit_pending, commit_done
   );

   modport slave (
      input  req, sync, num, wr_en, wr_addr, wr_data, commit, bright, rotate_en,
      output RGB, commit_pending, commit_done
   );

endinterface

// File: rtl/led_pixel_source_bank.sv
// Double-buffered pixel storage: host writes land in the back bank, reads come from the front bank.
module led_pixel_source_bank
   import led_pixel_source_pkg::*;
#(
   parameter int NUM_LEDS = 7
)
(
   input  logic clk,
   input  logic bank_sel,
   input  logic wr_en,
   input  idx_t wr_addr,
   input  rgb_t wr_data,
   input  idx_t rd_addr,
   output rgb_t rd_data
);

   localparam int             AW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_LEDS);

   logic wr_ok;
   logic rd_ok;
   rgb_t rd_word [2];

   assign wr_ok = ({1'b0, wr_addr} < LIMIT);
   assign rd_ok = ({1'b0, rd_addr} < LIMIT);

   for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic BANK_ID = 1'(gi);
      rgb_t mem [NUM_LEDS];

      // A bank only accepts writes while it is the back bank.
      always_ff @(posedge clk) begin
         if (wr_en && wr_ok && (bank_sel != BANK_ID)) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
         end
      end

      assign rd_word[gi] = mem[rd_addr[AW-1:0]];
   end

   assign rd_data = rd_ok ? rd_word[bank_sel] : '0;

endmodule

// File: rtl/led_pixel_source.sv
// Pixel supplier for LED_tape: frame detection, rotation, tear-free bank commit, scaling, RGB register.
module led_pixel_source
   import led_pixel_source_pkg::*;
#(
   parameter int NUM_LEDS  = 7,
   parameter int FRAME_DIV = 1
)
(
   input logic               clk,
   input logic               reset,
   led_pixel_source_if.slave bus
);

   localparam int             FCW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [IDX_W:0] LIMIT    = (IDX_W+1)'(NUM_LEDS);
   localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAME_DIV - 1);
   localparam idx_t           OFF_LAST = IDX_W'(NUM_LEDS - 1);

   logic           bank_sel_reg;
   logic           prev_sync_reg;
   logic           commit_pending_reg;
   logic           commit_done_reg;
   logic [FCW-1:0] frame_cnt_reg;
   idx_t           offset_reg;
   rgb_t           rgb_reg;
   rgb_t           rgb_next;
   rgb_t           front_pix;
   rgb_t           scaled_pix;
   logic [IDX_W:0] idx_sum;
   idx_t           rd_addr;
   logic           frame_event;
   logic           frame_wrap;
   logic           swap;

   // Both operands are below NUM_LEDS, so one conditional subtract wraps the index.
   assign idx_sum = {1'b0, bus.num} + {1'b0, offset_reg};
   assign rd_addr = IDX_W'((idx_sum >= LIMIT) ? idx_sum - LIMIT : idx_sum);

   led_pixel_source_bank #(
      .NUM_LEDS (NUM_LEDS)
   ) u_bank (
      .clk      (clk),
      .bank_sel (bank_sel_reg),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (front_pix)
   );

   for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_scale
      assign scaled_pix[gi*CHAN_W +: CHAN_W] =
         scale_chan(front_pix[gi*CHAN_W +: CHAN_W], bus.bright);
   end

   always_comb begin
      rgb_next = scaled_pix;
      if (bus.sync || ({1'b0, bus.num} >= LIMIT)) begin
         rgb_next = '0;
      end
   end

   // A frame starts at the first sync request following a non-sync request.
   assign frame_event = bus.req && bus.sync && !prev_sync_reg;
   assign frame_wrap  = frame_event && (frame_cnt_reg == FC_LAST);
   assign swap        = frame_event && commit_pending_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rgb_reg            <= '0;
         offset_reg         <= '0;
         frame_cnt_reg      <= '0;
         bank_sel_reg       <= 1'b0;
         commit_pending_reg <= 1'b0;
         commit_done_reg    <= 1'b0;
         prev_sync_reg      <= 1'b1;
      end else begin
         if (bus.req) begin
            rgb_reg       <= rgb_next;
            prev_sync_reg <= bus.sync;
         end
         commit_done_reg <= swap;
         if (swap) begin
            bank_sel_reg       <= !bank_sel_reg;
            commit_pending_reg <= 1'b0;
         end else if (bus.commit) begin
            commit_pending_reg <= 1'b1;
         end
         if (frame_event) begin
            frame_cnt_reg <= frame_wrap ? '0 : frame_cnt_reg + 1'b1;
         end
         if (frame_wrap && bus.rotate_en) begin
            offset_reg <= (offset_reg == OFF_LAST) ? '0 : offset_reg + 1'b1;
         end
      end
   end

   assign bus.RGB            = rgb_reg;
   assign bus.commit_pending = commit_pending_reg;
   assign bus.commit_done    = commit_done_reg;

endmodule

// File: tb/tb_led_pixel_source.sv
// Scoreboard bench for led_pixel_source: a behavioural model queues the expected outputs per cycle.
module tb_led_pixel_source;
   import led_pixel_source_pkg::*;

   localparam int N  = 7;
   localparam int FD = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   led_pixel_source_if bus();

   led_pixel_source #(
      .NUM_LEDS  (N),
      .FRAME_DIV (FD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [23:0] rgb;
      bit          rgb_known;
      bit          pend;
      bit          done;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   logic [23:0] m_bank [2][N];
   bit          m_ok   [2][N];
   bit          m_sel, m_prev, m_pend, m_done, m_rgb_ok;
   logic [23:0] m_rgb;
   int          m_off, m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [23:0] scl(input logic [23:0] p, input logic [7:0] b);
      int k;
      logic [23:0] r;
      k = int'(b) + 1;
      for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * k) >> 8);
      return r;
   endfunction

   task automatic drive(input bit rq, input bit sy, input logic [15:0] n, input bit we,
                        input logic [15:0] wa, input logic [23:0] wd, input bit cm, input bit rs);
      exp_t        e;
      bit          ev;
      logic [2:0]  ai;
      reset       = rs;
      bus.req     = rq;
      bus.sync    = sy;
      bus.num     = n;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.commit  = cm;
      // Writes go to whichever bank is back before this edge.
      if (we && int'(wa) < N) begin
         ai = 3'(int'(wa));
         m_bank[!m_sel][ai] = wd;
         m_ok[!m_sel][ai]   = 1'b1;
      end
      if (rs) begin
         m_rgb = '0; m_rgb_ok = 1'b1; m_off = 0; m_cnt = 0;
         m_sel = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_prev = 1'b1;
      end else begin
         ev = rq && sy && !m_prev;
         if (rq) begin
            if (sy || int'(n) >= N) begin
               m_rgb = '0; m_rgb_ok = 1'b1;
            end else begin
               ai       = 3'((int'(n) + m_off) % N);
               m_rgb    = scl(m_bank[m_sel][ai], bus.bright);
               m_rgb_ok = m_ok[m_sel][ai];
            end
            m_prev = sy;
         end
         m_done = ev && m_pend;
         if (ev && m_pend) begin
            m_sel = !m_sel; m_pend = 1'b0;
         end else if (cm) begin
            m_pend = 1'b1;
         end
         if (ev) begin
            if (m_cnt == FD - 1) begin
               m_cnt = 0;
               if (bus.rotate_en) m_off = (m_off + 1) % N;
            end else begin
               m_cnt++;
            end
         end
      end
      e.rgb = m_rgb; e.rgb_known = m_rgb_ok; e.pend = m_pend; e.done = m_done;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = sb_q.pop_front();
      if (e.rgb_known) chk("rgb", 32'(bus.RGB), 32'(e.rgb));
      chk("commit_pending", 32'(bus.commit_pending), 32'(e.pend));
      chk("commit_done", 32'(bus.commit_done), 32'(e.done));
      if (rq || rs)
         $display("txn cyc=%0d rst=%0b req=%0b sync=%0b num=%0d bright=%0d rgb=%h pend=%0b done=%0b",
                  cyc, rs, rq, sy, n, bus.bright, bus.RGB, bus.commit_pending, bus.commit_done);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 24'd0, 1'b0, 1'b0);
   endtask

   task automatic wr(input logic [15:0] a, input logic [23:0] d);
      drive(1'b0, 1'b0, 16'd0, 1'b1, a, d, 1'b0, 1'b0);
   endtask

   task automatic do_commit();
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 24'd0, 1'b1, 1'b0);
   endtask

   // One tape frame: pixels 0..N-1, an out-of-range index, then two sync slots.
   task automatic frame(input int cm_at, input bit do_wr, input logic [23:0] base, input bit cm_sync);
      for (int n = 0; n < N; n++) begin
         drive(1'b1, 1'b0, 16'(n), do_wr, 16'(n), base + 24'(n) * 24'h010101,
               (n == cm_at), 1'b0);
         if (n == 3) idle();
      end
      drive(1'b1, 1'b0, 16'd9, 1'b0, 16'd0, 24'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 16'd0, 1'b0, 16'd0, 24'd0, cm_sync, 1'b0);
      idle();
      drive(1'b1, 1'b1, 16'd1, 1'b0, 16'd0, 24'd0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < N; i++) m_ok[b][i] = 1'b0;
      m_prev = 1'b1; m_sel = 1'b0; m_pend = 1'b0; m_done = 1'b0;
      m_off = 0; m_cnt = 0; m_rgb = '0; m_rgb_ok = 1'b0;
      bus.bright    = 8'd255;
      bus.rotate_en = 1'b0;

      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 24'd0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 24'd0, 1'b0, 1'b1);

      // Basic read: ramp into the back bank, plus writes that must be ignored.
      for (int i = 0; i < N; i++) wr(16'(i), 24'h010203 * 24'(i + 1));
      wr(16'd7, 24'hABCDEF);
      wr(16'd8, 24'hABCDEF);
      wr(16'hFFFF, 24'hABCDEF);
      do_commit();
      frame(-1, 1'b0, 24'd0, 1'b0);
      frame(-1, 1'b0, 24'd0, 1'b0);

      // Brightness on front[0] = 0xFF8001.
      wr(16'd0, 24'hFF8001);
      for (int i = 1; i < N; i++) wr(16'(i), 24'h102030 * 24'(i));
      do_commit();
      frame(-1, 1'b0, 24'd0, 1'b0);
      bus.bright = 8'd127;
      frame(-1, 1'b0, 24'd0, 1'b0);
      bus.bright = 8'd0;
      frame(-1, 1'b0, 24'd0, 1'b0);
      bus.bright = 8'd255;

      // Commit mid-frame while rewriting the back bank, then commit on the event itself.
      frame(3, 1'b1, 24'h200000, 1'b0);
      frame(-1, 1'b0, 24'd0, 1'b0);
      frame(-1, 1'b0, 24'd0, 1'b1);
      frame(-1, 1'b0, 24'd0, 1'b0);
      frame(-1, 1'b0, 24'd0, 1'b0);

      // Rotation through more than one full wrap of the offset.
      bus.rotate_en = 1'b1;
      for (int f = 0; f < 20; f++) frame(-1, 1'b0, 24'd0, 1'b0);

      // Reset with a commit pending and a non-zero offset.
      do_commit();
      drive(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 24'd0, 1'b0, 1'b1);
      bus.rotate_en = 1'b0;
      frame(-1, 1'b0, 24'd0, 1'b0);
      frame(-1, 1'b0, 24'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
